paddle_assigner: RTL and testbench
==================================

# paddle_assigner

Parametrised successor to the four-port paddle chooser. It binds NUM_PORTS paddle outputs to NUM_SRC analog sticks (X or Y axis), NUM_SRC spinners and one PS/2 mouse. A port is claimed when its source makes a deliberate move to an extreme, or, for the mouse, when the button is pressed. A bound port can release after a programmable idle time, so a different controller can take it over without a cold reset. The block sits between the HPS input bus and the core's pot/paddle inputs.

## Interface
Parameters:
- NUM_PORTS, 4, paddle outputs (1..8)
- NUM_SRC, 4, controller sources (1..8)
- TIMEOUT_W, 24, idle counter width
- MOUSE_CLAMP, 64, max mouse delta per strobe

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- mask  in  NUM_PORTS  enabled ports
- use_multi  in  1  a stick may bind X and Y to different ports
- paddle_range  in  1  1 = mouse wraps, 0 = mouse clamps
- release_en  in  1  enable idle release
- timeout  in  TIMEOUT_W  idle cycles before release; 0 = never release
- mouse  in  25  [0] button, [4] X sign, [6] X overflow, [15:8] X delta, [24] strobe (toggles)
- analog  in  NUM_SRC×16  signed axes: [7:0] X, [15:8] Y
- spinner  in  NUM_SRC×8  unsigned spinner/paddle position
- buttons_in  in  NUM_SRC  primary fire buttons
- alt_b_in  in  NUM_SRC  alternate fire buttons
- assigned  out  NUM_PORTS  one-cycle pulse on bind
- released  out  NUM_PORTS  one-cycle pulse on idle release
- active  out  NUM_PORTS  port bound
- pd_out  out  NUM_PORTS×8  paddle position
- paddle_type  out  NUM_PORTS×2  0 = spinner, 1 = analog, 2 = mouse
- paddle_but  out  NUM_PORTS  paddle button
- is_paddle  out  NUM_SRC  source currently bound (analog or spinner)

## Operation
- Analog conversion: unsigned = {~v[7], v[6:0]}.
- Extreme detect, per X axis, Y axis and spinner: register the previous value. `sel` is registered high when the value differs from the previous value and the new value's bits [7:6] are 11 or 00.
- Port states are FREE and BOUND.
- Port y is eligible when it is FREE, mask[y]=1, and either y=0 or every lower enabled port is BOUND. Only the lowest eligible port is served, at most one bind per cycle.
- Candidate priority, highest first: X0..Xn, then Y0..Yn, then spinner 0..n, then mouse. Only unbound candidates count; the mouse candidate is `button=1`.
- Binding an X axis also marks the same stick's Y axis taken unless use_multi=1, and vice versa.
- With use_multi=1, a Y-bound port uses alt_b_in; all other analog ports use buttons_in.
- The mouse button is ORed with buttons_in[0] only while stick 0 has neither axis bound.
- pd_out for a BOUND port, combinational from the current source:
  - spinner: ~spinner
  - analog: ~unsigned axis
  - mouse: ~{~mx[7], mx[6:0]}
- A FREE port outputs pd_out=0 and paddle_but=0.
- Mouse accumulator mx is 9-bit signed:
  - delta = {mouse[4], mouse[15:8]}, clamped to ±MOUSE_CLAMP; overflow bit [6] forces ±MOUSE_CLAMP by sign.
  - On each strobe toggle, mx ← sum[7:0] sign-extended when paddle_range=1, otherwise sum saturated to −128..127.
- Idle release, per port:
  - The counter clears on bind and on any change of the bound source value. For the mouse, any strobe with nonzero delta or button=1 counts as activity.
  - Otherwise the counter increments, saturating.
  - When release_en=1, timeout≠0 and count==timeout, the port goes FREE, its source (and coupled axis) is freed, and released pulses.

## Timing
- Reset values: assigned, released, active, is_paddle, paddle_type = 0; pd_out = 0; paddle_but = 0; mx = 0; all counters and previous-value registers = 0.
- Bind latency: an input changes before edge k; sel is high in cycle k+1; active and assigned are high after edge k+1, giving 2 cycles.
- A mouse button press binds after 1 edge, because the button is not edge-registered.
- mx updates on the edge after the strobe toggle is seen; strobe history is one register.
- Release on port p and an eligible bind on the same edge: release wins. The freed source and port cannot rebind until the following edge.
- Two ports never bind on one edge. The second bind follows on a later edge with a fresh sel.
- A source already bound is ignored by all ports until it is released.
- Deasserting mask for a BOUND port does not unbind it. The port stays BOUND until reset or release.
- Reset asserted mid-operation clears everything on that edge; inputs are ignored while reset=1.

## Test plan
- Stick 1 X moves 0x00→0x7F, mask=4'b0011 → assigned[0] pulses 2 cycles later; paddle_type[0]=1; pd_out[0]=~0xFF=0x00; is_paddle[1]=1.
- Same move with use_multi=0, then stick 1 Y moves to 0x80 → no bind. Repeat with use_multi=1 → port 1 binds Y, and paddle_but[1] follows alt_b_in[1].
- Mouse button press with ports free and mask=1 → port 0 is type 2. Eight strobes with delta +100 and paddle_range=0 → mx saturates at 127 (64, then 127), pd_out=0x00. With paddle_range=1 → mx wraps to −128 on the second strobe.
- timeout=100, release_en=1, spinner 2 bound to port 0 and held → released[0] pulses 100 cycles after the last change; active[0]=0. Next extreme move rebinds it.
- Spinner 0 and stick 0 X hit extremes on the same cycle → port 0 gets X0 one edge later and spinner 0 stays unbound. A new spinner extreme binds spinner 0 to port 1.
- Reset pulsed while three ports are bound and mx=50 → all outputs 0 on the next cycle, and mx=0.

Source files
------------

// File: rtl/paddle_assigner.sv
// paddle_assigner
// Binds NUM_PORTS paddle outputs to NUM_SRC analog sticks (X or Y axis),
// NUM_SRC spinners and one PS/2 mouse. A port is claimed by a deliberate move
// of a source to an extreme (or a mouse button press). It can be released
// after a programmable idle time so another controller can take it over.
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   mask           ports allowed to bind
//   use_multi      X and Y of one stick may go to different ports
//   paddle_range   1 = mouse accumulator wraps, 0 = saturates
//   release_en     enable idle release
//   timeout        idle cycles before release (0 = never)
//   mouse          PS/2 packet: [0] button, [4] X sign, [6] X ovf, [15:8] dX, [24] strobe
//   analog         signed stick axes per source: [7:0] X, [15:8] Y
//   spinner        unsigned spinner position per source
//   buttons_in     primary fire per source
//   alt_b_in       alternate fire per source
//   assigned       one-cycle pulse when a port binds
//   released       one-cycle pulse when a port is released on idle
//   active         port bound
//   pd_out         paddle position per port (8 bits each)
//   paddle_type    per port: 0 spinner, 1 analog, 2 mouse
//   paddle_but     paddle button per port
//   is_paddle      source bound as analog stick or spinner
module paddle_assigner #(
    parameter int NUM_PORTS   = 4,
    parameter int NUM_SRC     = 4,
    parameter int TIMEOUT_W   = 24,
    parameter int MOUSE_CLAMP = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   mask,
    input  logic                   use_multi,
    input  logic                   paddle_range,
    input  logic                   release_en,
    input  logic [TIMEOUT_W-1:0]   timeout,
    input  logic [24:0]            mouse,
    input  logic [NUM_SRC*16-1:0]  analog,
    input  logic [NUM_SRC*8-1:0]   spinner,
    input  logic [NUM_SRC-1:0]     buttons_in,
    input  logic [NUM_SRC-1:0]     alt_b_in,
    output logic [NUM_PORTS-1:0]   assigned,
    output logic [NUM_PORTS-1:0]   released,
    output logic [NUM_PORTS-1:0]   active,
    output logic [NUM_PORTS*8-1:0] pd_out,
    output logic [NUM_PORTS*2-1:0] paddle_type,
    output logic [NUM_PORTS-1:0]   paddle_but,
    output logic [NUM_SRC-1:0]     is_paddle
);

    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] K_SPIN  = 2'd0;
    localparam logic [1:0] K_X     = 2'd1;
    localparam logic [1:0] K_Y     = 2'd2;
    localparam logic [1:0] K_MOUSE = 2'd3;

    localparam logic signed [8:0] CLAMP_P = 9'(MOUSE_CLAMP);
    localparam logic signed [8:0] CLAMP_N = -CLAMP_P;

    function automatic logic [7:0] to_unsigned(input logic [7:0] v);
        return {~v[7], v[6:0]};
    endfunction

    function automatic logic is_extreme(input logic [7:0] v);
        return (v[7:6] == 2'b11) || (v[7:6] == 2'b00);
    endfunction

    // Overflow forces the full clamp in the direction of the sign bit.
    function automatic logic signed [8:0] clamp_delta(input logic [24:0] m);
        logic signed [8:0] d;
        d = $signed({m[4], m[15:8]});
        if (m[6]) return m[4] ? CLAMP_N : CLAMP_P;
        if (d > CLAMP_P) return CLAMP_P;
        if (d < CLAMP_N) return CLAMP_N;
        return d;
    endfunction

    function automatic logic signed [8:0] mouse_acc(input logic signed [8:0] acc,
                                                    input logic signed [8:0] d,
                                                    input logic wrap);
        logic signed [9:0] sum;
        sum = $signed({acc[8], acc}) + $signed({d[8], d});
        if (wrap) return $signed({sum[7], sum[7:0]});
        if (sum > 10'sd127) return 9'sd127;
        if (sum < -10'sd128) return -9'sd128;
        return sum[8:0];
    endfunction

    // Per-source state
    logic [7:0]         ux [NUM_SRC];
    logic [7:0]         uy [NUM_SRC];
    logic [7:0]         sp [NUM_SRC];
    logic [7:0]         prev_x [NUM_SRC];
    logic [7:0]         prev_y [NUM_SRC];
    logic [7:0]         prev_sp [NUM_SRC];
    logic [NUM_SRC-1:0] sel_x, sel_y, sel_sp;

    // Mouse state
    logic              strobe_d;
    logic              strobe_tgl;
    logic signed [8:0] mx;
    logic signed [8:0] mdelta;
    logic              mouse_act;
    logic              unused_mouse;

    // Per-port state
    logic [NUM_PORTS-1:0] bound;
    logic [NUM_PORTS-1:0] coupled;
    logic [1:0]           kind [NUM_PORTS];
    logic [SRC_W-1:0]     idx [NUM_PORTS];
    logic [TIMEOUT_W-1:0] cnt [NUM_PORTS];

    // Derived
    logic [NUM_SRC-1:0]   taken_x, taken_y, taken_sp, ana_bound;
    logic                 taken_m;
    logic [7:0]           src_val [NUM_PORTS];
    logic [7:0]           src_prev [NUM_PORTS];
    logic [NUM_PORTS-1:0] src_btn, src_alt;
    logic [NUM_PORTS-1:0] act, rel;
    logic                 cand_vld;
    logic [1:0]           cand_kind;
    logic [SRC_W-1:0]     cand_idx;
    logic                 tgt_vld;
    logic [PORT_W-1:0]    tgt;
    logic                 do_bind;

    assign unused_mouse = ^{mouse[23:16], mouse[7], mouse[5], mouse[3:1]};

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            ux[s] = to_unsigned(analog[s*16 +: 8]);
            uy[s] = to_unsigned(analog[s*16+8 +: 8]);
            sp[s] = spinner[s*8 +: 8];
        end
    end

    assign strobe_tgl = mouse[24] ^ strobe_d;
    assign mdelta     = clamp_delta(mouse);
    assign mouse_act  = (strobe_tgl && (mdelta != 9'sd0)) || mouse[0];

    // A coupled binding reserves the sibling axis of the same stick.
    always_comb begin
        taken_x   = '0;
        taken_y   = '0;
        taken_sp  = '0;
        ana_bound = '0;
        taken_m   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bound[p]) begin
                if (kind[p] == K_MOUSE) taken_m = 1'b1;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (idx[p] == SRC_W'(s)) begin
                        case (kind[p])
                            K_X: begin
                                taken_x[s]   = 1'b1;
                                ana_bound[s] = 1'b1;
                                if (coupled[p]) taken_y[s] = 1'b1;
                            end
                            K_Y: begin
                                taken_y[s]   = 1'b1;
                                ana_bound[s] = 1'b1;
                                if (coupled[p]) taken_x[s] = 1'b1;
                            end
                            K_SPIN:  taken_sp[s] = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign is_paddle = ana_bound | taken_sp;
    assign active    = bound;

    // Candidates scanned lowest priority first so higher ones overwrite.
    always_comb begin
        cand_vld  = 1'b0;
        cand_kind = K_MOUSE;
        cand_idx  = '0;
        if (mouse[0] && !taken_m) cand_vld = 1'b1;
        for (int s = NUM_SRC-1; s >= 0; s--) begin
            if (sel_sp[s] && !taken_sp[s]) begin
                cand_vld = 1'b1; cand_kind = K_SPIN; cand_idx = SRC_W'(s);
            end
        end
        for (int s = NUM_SRC-1; s >= 0; s--) begin
            if (sel_y[s] && !taken_y[s]) begin
                cand_vld = 1'b1; cand_kind = K_Y; cand_idx = SRC_W'(s);
            end
        end
        for (int s = NUM_SRC-1; s >= 0; s--) begin
            if (sel_x[s] && !taken_x[s]) begin
                cand_vld = 1'b1; cand_kind = K_X; cand_idx = SRC_W'(s);
            end
        end
    end

    // Only the lowest enabled free port can be eligible.
    always_comb begin
        tgt_vld = 1'b0;
        tgt     = '0;
        for (int p = NUM_PORTS-1; p >= 0; p--) begin
            if (mask[p] && !bound[p]) begin
                tgt_vld = 1'b1;
                tgt     = PORT_W'(p);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            src_val[p]  = '0;
            src_prev[p] = '0;
            src_btn[p]  = 1'b0;
            src_alt[p]  = 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (idx[p] == SRC_W'(s)) begin
                    src_btn[p] = buttons_in[s];
                    src_alt[p] = alt_b_in[s];
                    case (kind[p])
                        K_X:     begin src_val[p] = ux[s]; src_prev[p] = prev_x[s];  end
                        K_Y:     begin src_val[p] = uy[s]; src_prev[p] = prev_y[s];  end
                        default: begin src_val[p] = sp[s]; src_prev[p] = prev_sp[s]; end
                    endcase
                end
            end
            act[p] = (kind[p] == K_MOUSE) ? mouse_act : (src_val[p] != src_prev[p]);
            rel[p] = bound[p] && release_en && (timeout != '0) && (cnt[p] == timeout);
        end
    end

    // A release anywhere suppresses binding on the same edge.
    assign do_bind = tgt_vld && cand_vld && !(|rel);

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            pd_out[p*8 +: 8]      = '0;
            paddle_type[p*2 +: 2] = 2'd0;
            paddle_but[p]         = 1'b0;
            if (bound[p]) begin
                case (kind[p])
                    K_SPIN: begin
                        pd_out[p*8 +: 8] = ~src_val[p];
                        paddle_but[p]    = src_btn[p];
                    end
                    K_X: begin
                        pd_out[p*8 +: 8]      = ~src_val[p];
                        paddle_type[p*2 +: 2] = 2'd1;
                        paddle_but[p]         = src_btn[p];
                    end
                    K_Y: begin
                        pd_out[p*8 +: 8]      = ~src_val[p];
                        paddle_type[p*2 +: 2] = 2'd1;
                        paddle_but[p]         = use_multi ? src_alt[p] : src_btn[p];
                    end
                    default: begin
                        pd_out[p*8 +: 8]      = ~{~mx[7], mx[6:0]};
                        paddle_type[p*2 +: 2] = 2'd2;
                        paddle_but[p]         = mouse[0] | (buttons_in[0] & ~ana_bound[0]);
                    end
                endcase
            end
        end
    end

    // Edge-detect / accumulator stage and port state update
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_d <= 1'b0;
            mx       <= '0;
            sel_x    <= '0;
            sel_y    <= '0;
            sel_sp   <= '0;
            bound    <= '0;
            coupled  <= '0;
            assigned <= '0;
            released <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                prev_x[s]  <= '0;
                prev_y[s]  <= '0;
                prev_sp[s] <= '0;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                kind[p] <= K_SPIN;
                idx[p]  <= '0;
                cnt[p]  <= '0;
            end
        end else begin
            strobe_d <= mouse[24];
            if (strobe_tgl) mx <= mouse_acc(mx, mdelta, paddle_range);
            for (int s = 0; s < NUM_SRC; s++) begin
                prev_x[s]  <= ux[s];
                prev_y[s]  <= uy[s];
                prev_sp[s] <= sp[s];
                sel_x[s]   <= (ux[s] != prev_x[s]) && is_extreme(ux[s]);
                sel_y[s]   <= (uy[s] != prev_y[s]) && is_extreme(uy[s]);
                sel_sp[s]  <= (sp[s] != prev_sp[s]) && is_extreme(sp[s]);
            end
            assigned <= '0;
            released <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rel[p]) begin
                    bound[p]    <= 1'b0;
                    released[p] <= 1'b1;
                    cnt[p]      <= '0;
                end else if (do_bind && (tgt == PORT_W'(p))) begin
                    bound[p]    <= 1'b1;
                    kind[p]     <= cand_kind;
                    idx[p]      <= cand_idx;
                    coupled[p]  <= ~use_multi;
                    cnt[p]      <= '0;
                    assigned[p] <= 1'b1;
                end else if (bound[p]) begin
                    if (act[p])
                        cnt[p] <= '0;
                    else if (cnt[p] != '1)
                        cnt[p] <= cnt[p] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_assigner.sv
// Directed bench for paddle_assigner: binding latency and priority, axis
// coupling, alternate buttons, mouse accumulator clamp/saturate/wrap, idle
// release and rebind, and mid-operation reset.
module tb_paddle_assigner;

    localparam int NP = 4;
    localparam int NS = 4;
    localparam int TW = 24;

    logic            clk;
    logic            reset;
    logic [NP-1:0]   mask;
    logic            use_multi;
    logic            paddle_range;
    logic            release_en;
    logic [TW-1:0]   timeout;
    logic [24:0]     mouse;
    logic [NS*16-1:0] analog;
    logic [NS*8-1:0] spinner;
    logic [NS-1:0]   buttons_in;
    logic [NS-1:0]   alt_b_in;
    logic [NP-1:0]   assigned;
    logic [NP-1:0]   released;
    logic [NP-1:0]   active;
    logic [NP*8-1:0] pd_out;
    logic [NP*2-1:0] paddle_type;
    logic [NP-1:0]   paddle_but;
    logic [NS-1:0]   is_paddle;

    int n_checks = 0;
    int n_fail   = 0;

    paddle_assigner #(
        .NUM_PORTS(NP), .NUM_SRC(NS), .TIMEOUT_W(TW), .MOUSE_CLAMP(64)
    ) dut (
        .clk(clk), .reset(reset), .mask(mask), .use_multi(use_multi),
        .paddle_range(paddle_range), .release_en(release_en), .timeout(timeout),
        .mouse(mouse), .analog(analog), .spinner(spinner),
        .buttons_in(buttons_in), .alt_b_in(alt_b_in),
        .assigned(assigned), .released(released), .active(active),
        .pd_out(pd_out), .paddle_type(paddle_type), .paddle_but(paddle_but),
        .is_paddle(is_paddle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic init_inputs();
        mask         = '0;
        use_multi    = 1'b0;
        paddle_range = 1'b0;
        release_en   = 1'b0;
        timeout      = '0;
        mouse        = '0;
        analog       = '0;
        spinner      = {NS{8'h80}};
        buttons_in   = '0;
        alt_b_in     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        init_inputs();
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic set_x(input int s, input logic [7:0] v);
        analog[s*16 +: 8] = v;
    endtask

    task automatic set_y(input int s, input logic [7:0] v);
        analog[s*16+8 +: 8] = v;
    endtask

    task automatic set_sp(input int s, input logic [7:0] v);
        spinner[s*8 +: 8] = v;
    endtask

    task automatic strobe();
        mouse[24] = ~mouse[24];
        step(1);
    endtask

    initial begin
        reset = 1'b1;
        init_inputs();
        do_reset();
        check("rst_active", active, 0);
        check("rst_assigned", assigned, 0);
        check("rst_released", released, 0);
        check("rst_pd_out", pd_out, 0);
        check("rst_type", paddle_type, 0);
        check("rst_but", paddle_but, 0);
        check("rst_is_paddle", is_paddle, 0);

        // Stick 1 X to the extreme, coupled axes
        mask = 4'b0011;
        set_x(1, 8'h7F);
        step(1);
        check("x1_not_yet", active, 0);
        step(1);
        check("x1_assigned", assigned, 4'b0001);
        check("x1_active", active, 4'b0001);
        check("x1_type", paddle_type, 8'h01);
        check("x1_pd", pd_out[7:0], 8'h00);
        check("x1_is_paddle", is_paddle, 4'b0010);
        buttons_in = 4'b0010;
        #1;
        check("x1_but", paddle_but, 4'b0001);
        step(1);
        check("x1_assigned_pulse", assigned, 0);
        set_y(1, 8'h80);
        step(3);
        check("y1_coupled_no_bind", active, 4'b0001);

        // Same with use_multi: Y binds separately and takes alt_b_in
        do_reset();
        use_multi = 1'b1;
        mask = 4'b0011;
        set_x(1, 8'h7F);
        step(2);
        check("mx_x1_active", active, 4'b0001);
        set_y(1, 8'h80);
        step(2);
        check("mx_y1_active", active, 4'b0011);
        check("mx_y1_type", paddle_type, 8'h05);
        check("mx_y1_pd", pd_out[15:8], 8'hFF);
        alt_b_in = 4'b0010;
        #1;
        check("mx_alt_but", paddle_but, 4'b0010);
        alt_b_in = 4'b0000;
        buttons_in = 4'b0010;
        #1;
        check("mx_pri_but", paddle_but, 4'b0001);

        // Mouse bind, clamp and saturate
        do_reset();
        mask = 4'b0001;
        mouse[0] = 1'b1;
        step(1);
        check("m_active", active, 4'b0001);
        check("m_type", paddle_type, 8'h02);
        mouse[0] = 1'b0;
        mouse[15:8] = 8'd100;
        #1;
        check("m_pd_zero", pd_out[7:0], 8'h7F);
        buttons_in = 4'b0001;
        #1;
        check("m_but_or", paddle_but, 4'b0001);
        buttons_in = 4'b0000;
        strobe();
        check("m_pd_64", pd_out[7:0], 8'h3F);
        strobe();
        check("m_pd_127", pd_out[7:0], 8'h00);
        for (int i = 0; i < 6; i++) strobe();
        check("m_pd_sat", pd_out[7:0], 8'h00);
        mouse[4] = 1'b1;
        mouse[6] = 1'b1;
        strobe();
        check("m_pd_ovf_neg", pd_out[7:0], 8'h40);

        // Mouse wrap
        do_reset();
        paddle_range = 1'b1;
        mask = 4'b0001;
        mouse[0] = 1'b1;
        step(1);
        mouse[0] = 1'b0;
        mouse[15:8] = 8'd100;
        strobe();
        check("w_pd_64", pd_out[7:0], 8'h3F);
        strobe();
        check("w_pd_wrap", pd_out[7:0], 8'hFF);

        // Idle release of spinner 2, then rebind
        do_reset();
        mask = 4'b0001;
        timeout = 24'd100;
        release_en = 1'b1;
        set_sp(2, 8'hFF);
        step(2);
        check("t_assigned", assigned, 4'b0001);
        check("t_type", paddle_type, 8'h00);
        check("t_pd", pd_out[7:0], 8'h00);
        check("t_is_paddle", is_paddle, 4'b0100);
        step(100);
        check("t_not_early", released, 0);
        check("t_still_active", active, 4'b0001);
        step(1);
        check("t_released", released, 4'b0001);
        check("t_inactive", active, 0);
        step(1);
        check("t_released_pulse", released, 0);
        set_sp(2, 8'h00);
        step(2);
        check("t_rebind", active, 4'b0001);
        check("t_rebind_pd", pd_out[7:0], 8'hFF);

        // X0 beats spinner 0 on the same cycle
        do_reset();
        mask = 4'b0011;
        set_sp(0, 8'hFF);
        set_x(0, 8'h7F);
        step(2);
        check("p_active", active, 4'b0001);
        check("p_type", paddle_type, 8'h01);
        step(2);
        check("p_sp_unbound", active, 4'b0001);
        set_sp(0, 8'h00);
        step(2);
        check("p_sp_bind", active, 4'b0011);
        check("p_sp_type", paddle_type, 8'h01);
        check("p_sp_pd", pd_out[15:8], 8'hFF);

        // Reset mid-operation
        do_reset();
        mask = 4'b0111;
        set_x(0, 8'h7F);
        step(2);
        set_sp(1, 8'hFF);
        step(2);
        mouse[0] = 1'b1;
        step(1);
        mouse[0] = 1'b0;
        mouse[15:8] = 8'd50;
        strobe();
        check("r_active", active, 4'b0111);
        check("r_type", paddle_type, 8'h21);
        check("r_pd_mouse", pd_out[23:16], 8'h4D);
        reset = 1'b1;
        step(1);
        check("r_cleared_active", active, 0);
        check("r_cleared_pd", pd_out, 0);
        check("r_cleared_type", paddle_type, 0);
        check("r_cleared_is_paddle", is_paddle, 0);
        init_inputs();
        mask = 4'b0001;
        reset = 1'b0;
        step(1);
        mouse[0] = 1'b1;
        step(1);
        mouse[0] = 1'b0;
        #1;
        check("r_mouse_active", active, 4'b0001);
        check("r_mx_zero", pd_out[7:0], 8'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
